instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_pkg.sv | 13 +
 rtl/instr_ram.sv | 27 ++
 rtl/instr_loader.sv | 127 ++++++++++++
 tb/tb_instr_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction loader: FSM state type and ISA word width.
package instr_pkg;

  localparam int W         = 9;
  localparam int D_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_ram.sv
// Instruction memory: one synchronous write port, one combinational read port.
module instr_ram
  import instr_pkg::*;
#(
  parameter int D = D_DEFAULT,
  parameter int W = instr_pkg::W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] progCtr,
  output logic [W-1:0] machineCode
);

  // Contents deliberately have no reset so a reload can be partial.
  logic [W-1:0] mem [0:(1<<D)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign machineCode = mem[progCtr];

endmodule

// File: rtl/instr_loader.sv
// Streams machine-code words into instruction memory while holding the core,
// tracking word count and a running XOR checksum of the accepted words.
module instr_loader
  import instr_pkg::*;
#(
  parameter int D = D_DEFAULT,
  parameter int W = instr_pkg::W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [D:0]   len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic [D-1:0] progCtr,
  output logic [W-1:0] machineCode,
  output logic         busy,
  output logic         core_hold,
  output logic         load_done,
  output logic [W-1:0] checksum,
  output logic         err_len
);

  localparam logic [D:0] MAX_LEN = (D+1)'(1) << D;

  state_t       state, state_nxt;
  logic [D-1:0] addr;
  logic [D:0]   cnt;
  logic [D:0]   cnt_inc;
  logic [D:0]   len_q;
  logic         accept;
  logic         len_ok;
  logic         xfer;
  logic         last;

  assign accept  = start && (state != LOAD);
  assign len_ok  = (len <= MAX_LEN);
  assign xfer    = in_valid && (state == LOAD);
  assign cnt_inc = cnt + (D+1)'(1);
  assign last    = xfer && (cnt_inc == len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          if (!len_ok) begin
            state_nxt = IDLE;
          end else if (len == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    core_hold = 1'b0;
    load_done = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
      end
      DONE:    load_done = 1'b1;
      default: ;
    endcase
  end

  // A rejected length only raises the error flag; counters and checksum keep their values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      cnt      <= '0;
      len_q    <= '0;
      checksum <= '0;
      err_len  <= 1'b0;
    end else if (accept) begin
      if (len_ok) begin
        addr     <= '0;
        cnt      <= '0;
        len_q    <= len;
        checksum <= '0;
        err_len  <= 1'b0;
      end else begin
        err_len  <= 1'b1;
      end
    end else if (xfer) begin
      addr     <= addr + 1'b1;
      cnt      <= cnt_inc;
      checksum <= checksum ^ in_data;
    end
  end

  instr_ram #(
    .D (D),
    .W (W)
  ) u_ram (
    .clk         (clk),
    .we          (xfer),
    .waddr       (addr),
    .wdata       (in_data),
    .progCtr     (progCtr),
    .machineCode (machineCode)
  );

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader with a small memory (D=4).
module tb_instr_loader;

  localparam int D     = 4;
  localparam int W     = 9;
  localparam int DEPTH = 1 << D;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [D:0]   len = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [D-1:0] progCtr = '0;
  logic         in_ready, busy, core_hold, load_done, err_len;
  logic [W-1:0] machineCode, checksum;

  instr_loader #(.D(D), .W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .progCtr     (progCtr),
    .machineCode (machineCode),
    .busy        (busy),
    .core_hold   (core_hold),
    .load_done   (load_done),
    .checksum    (checksum),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ck;
    int unsigned  n;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur_words[$];
  int           passed = 0;
  int           total  = 0;

  // Reference model: memory image plus load bookkeeping.
  logic [W-1:0] m_mem [DEPTH];
  bit           m_loading = 0;
  bit           m_err = 0;
  int unsigned  m_addr = 0;
  int unsigned  m_target = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int unsigned n);
    cur_words.delete();
    for (int unsigned i = 0; i < n; i++) cur_words.push_back(W'($urandom));
  endtask

  task automatic do_start(input int unsigned n);
    start = 1'b1;
    len   = (D+1)'(n);
    tick();
    start = 1'b0;
    if (!m_loading) begin
      if (n > DEPTH) m_err = 1;
      else begin
        m_err     = 0;
        m_addr    = 0;
        m_target  = n;
        m_loading = (n != 0);
      end
    end
    chk("err_len", err_len, m_err);
  endtask

  // mode 0: back-to-back, 1: idle cycle before every word, 2: random gaps
  task automatic send_words(input int unsigned first, input int unsigned last, input int mode);
    for (int unsigned i = first; i < last; i++) begin
      int unsigned gaps;
      gaps = (mode == 1) ? 1 : ((mode == 2) ? $urandom_range(0, 2) : 0);
      for (int unsigned g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        tick();
        chk("hold_busy", busy, 1);
        chk("ready_wo_valid", in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = cur_words[i];
      progCtr  = D'(m_addr % DEPTH);
      chk("busy", busy, 1);
      chk("core_hold", core_hold, 1);
      tick();
      in_valid = 1'b0;
      m_mem[m_addr % DEPTH] = cur_words[i];
      m_addr++;
      chk("rd_after_wr", machineCode, cur_words[i]);
      if (m_loading && m_addr == m_target) begin
        m_loading = 0;
        chk("done_after_last", load_done, 1);
        chk("busy_after_last", busy, 0);
        chk("ready_after_last", in_ready, 0);
      end
    end
  endtask

  task automatic run_load(input int unsigned n, input int mode, input int unsigned nsend);
    logic [W-1:0] ck;
    ck = '0;
    for (int unsigned i = 0; i < n; i++) ck ^= cur_words[i];
    exp_q.push_back('{ck, n});
    do_start(n);
    send_words(0, nsend, mode);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      progCtr = D'(i);
      #1;
      chk(tag, machineCode, m_mem[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hold"}, core_hold, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_cksum"}, checksum, 0);
    chk({tag, "_err"}, err_len, 0);
  endtask

  // Monitor: on each rising load_done, pop the expected checksum and word count.
  initial begin : monitor
    int unsigned xfers;
    bit          prev_done;
    exp_t        e;
    xfers = 0;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        xfers = 0;
        prev_done = 0;
      end else begin
        if (load_done && !prev_done) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL sb_unexpected_done: got load_done=1 expected no completion");
          end else begin
            e = exp_q.pop_front();
            chk("sb_checksum", checksum, e.ck);
            chk("sb_count", xfers, e.n);
          end
          xfers = 0;
        end
        if (in_valid && in_ready) xfers++;
        prev_done = load_done;
      end
    end
  end

  initial begin : stimulus
    repeat (3) tick();
    check_reset_outputs("rst_low");
    reset_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // Full-depth load initialises the memory and exercises address wrap.
    fill_random(DEPTH);
    run_load(DEPTH, 2, DEPTH);
    check_mem("mem_full");

    cur_words.delete();
    cur_words.push_back(9'h101);
    cur_words.push_back(9'h0AA);
    cur_words.push_back(9'h1FF);
    run_load(3, 0, 3);
    check_mem("mem_b2b");
    run_load(3, 1, 3);
    check_mem("mem_toggle");

    do_start(DEPTH + 1);
    chk("err_busy", busy, 0);
    chk("err_done", load_done, 0);
    chk("err_ready", in_ready, 0);

    cur_words.delete();
    run_load(0, 0, 0);
    in_valid = 1'b1;
    in_data  = W'($urandom);
    repeat (2) begin
      chk("len0_ready", in_ready, 0);
      chk("len0_done", load_done, 1);
      tick();
    end
    in_valid = 1'b0;
    check_mem("mem_len0");

    do_start(DEPTH + 1);
    chk("err_set", err_len, 1);
    fill_random(1);
    run_load(1, 0, 1);
    chk("err_cleared", err_len, 0);

    // Abort after two of four words.
    fill_random(4);
    run_load(4, 0, 2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    m_loading = 0;
    m_err = 0;
    tick();
    check_reset_outputs("rst_after");
    check_mem("mem_abort");

    // Start during LOAD is ignored.
    fill_random(4);
    run_load(4, 0, 2);
    do_start(2);
    chk("ign_busy", busy, 1);
    send_words(2, 4, 0);
    chk("ign_done", load_done, 1);
    check_mem("mem_ignore");

    for (int k = 0; k < 10; k++) begin
      int unsigned n;
      if ($urandom_range(0, 3) == 0) begin
        do_start(DEPTH + 1 + $urandom_range(0, DEPTH - 2));
        chk("rnd_err_idle", load_done, 0);
      end
      n = $urandom_range(1, DEPTH);
      fill_random(n);
      run_load(n, 2, n);
    end
    check_mem("mem_rand");

    repeat (3) tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
